// File: rtl/wb_la_res_arbiter.sv
// Round-robin arbiter giving the Wishbone slave port and the LA command port turns on one shared resource.
// Optional ARB_TIMEOUT_EN: bounds the resource wait and reports a sticky error.
module wb_la_res_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ADDR_W      = 8,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [31:0]       la_dat_i,
  output logic              la_ack_o,
  output logic [31:0]       la_dat_o,
  output logic              res_req_o,
  output logic              res_we_o,
  output logic [3:0]        res_sel_o,
  output logic [ADDR_W-1:0] res_adr_o,
  output logic [31:0]       res_dat_o,
  input  logic              res_ack_i,
  input  logic [31:0]       res_dat_i,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_WB, S_GNT_LA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_last_la_q, rr_last_la_d;
  logic              gnt_la_q, gnt_la_d;
  logic              res_req_q, res_req_d;
  logic              res_we_q, res_we_d;
  logic [3:0]        res_sel_q, res_sel_d;
  logic [ADDR_W-1:0] res_adr_q, res_adr_d;
  logic [31:0]       res_dat_q, res_dat_d;
  logic [31:0]       wbs_dat_q, wbs_dat_d;
  logic [31:0]       la_dat_q, la_dat_d;
  logic              wb_hit, la_hit, in_gnt;

  // Byte-lane bits of the WB address carry no meaning for word accesses.
  logic unused_ok;
  assign unused_ok = ^wbs_adr_i[1:0];

  assign wb_hit = wbs_cyc_i & wbs_stb_i &
                  (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign la_hit = la_req_i;
  assign in_gnt = (state_q == S_GNT_WB) || (state_q == S_GNT_LA);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             expire;

  assign expire = in_gnt && !res_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err_o  = err_q;
`else
  logic expire;
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_last_la_d = rr_last_la_q;
    gnt_la_d     = gnt_la_q;
    res_req_d    = res_req_q;
    res_we_d     = res_we_q;
    res_sel_d    = res_sel_q;
    res_adr_d    = res_adr_q;
    res_dat_d    = res_dat_q;
    wbs_dat_d    = wbs_dat_q;
    la_dat_d     = la_dat_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // On contention the requester that did not win last time goes first.
        if (wb_hit && (!la_hit || rr_last_la_q)) begin
          state_d      = S_GNT_WB;
          rr_last_la_d = 1'b0;
          gnt_la_d     = 1'b0;
          res_req_d    = 1'b1;
          res_we_d     = wbs_we_i;
          res_sel_d    = wbs_sel_i;
          res_adr_d    = wbs_adr_i[ADDR_W+1:2];
          res_dat_d    = wbs_dat_i;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else if (la_hit) begin
          state_d      = S_GNT_LA;
          rr_last_la_d = 1'b1;
          gnt_la_d     = 1'b1;
          res_req_d    = 1'b1;
          res_we_d     = la_we_i;
          res_sel_d    = 4'hF;
          res_adr_d    = la_adr_i;
          res_dat_d    = la_dat_i;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      S_GNT_WB, S_GNT_LA: begin
        if (res_ack_i) begin
          state_d   = S_DONE;
          res_req_d = 1'b0;
          if (!res_we_q) begin
            if (gnt_la_q) la_dat_d  = res_dat_i;
            else          wbs_dat_d = res_dat_i;
          end
        end else if (expire) begin
          state_d   = S_DONE;
          res_req_d = 1'b0;
          if (gnt_la_q) la_dat_d  = 32'hDEAD_BEEF;
          else          wbs_dat_d = 32'hDEAD_BEEF;
`ifdef ARB_TIMEOUT_EN
          err_d     = 1'b1;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      rr_last_la_q <= 1'b1;
      gnt_la_q     <= 1'b0;
      res_req_q    <= 1'b0;
      res_we_q     <= 1'b0;
      res_sel_q    <= '0;
      res_adr_q    <= '0;
      res_dat_q    <= '0;
      wbs_dat_q    <= '0;
      la_dat_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_la_q <= rr_last_la_d;
      gnt_la_q     <= gnt_la_d;
      res_req_q    <= res_req_d;
      res_we_q     <= res_we_d;
      res_sel_q    <= res_sel_d;
      res_adr_q    <= res_adr_d;
      res_dat_q    <= res_dat_d;
      wbs_dat_q    <= wbs_dat_d;
      la_dat_q     <= la_dat_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign wbs_ack_o = (state_q == S_DONE) && !gnt_la_q;
  assign la_ack_o  = (state_q == S_DONE) &&  gnt_la_q;
  assign wbs_dat_o = wbs_dat_q;
  assign la_dat_o  = la_dat_q;
  assign res_req_o = res_req_q;
  assign res_we_o  = res_we_q;
  assign res_sel_o = res_sel_q;
  assign res_adr_o = res_adr_q;
  assign res_dat_o = res_dat_q;

endmodule

// File: tb/tb_wb_la_res_arbiter.sv
// Directed bench for wb_la_res_arbiter: resource-side and requester-side scoreboards.
module tb_wb_la_res_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req, la_we;
  logic [7:0]  la_adr;
  logic [31:0] la_dat;
  logic        la_ack_o;
  logic [31:0] la_dat_o;
  logic        res_req_o, res_we_o;
  logic [3:0]  res_sel_o;
  logic [7:0]  res_adr_o;
  logic [31:0] res_dat_o;
  logic        res_ack;
  logic [31:0] res_rdat;
  logic        err_o;

  always #5 clk = ~clk;

  wb_la_res_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req), .la_we_i(la_we), .la_adr_i(la_adr), .la_dat_i(la_dat),
    .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
    .res_req_o(res_req_o), .res_we_o(res_we_o), .res_sel_o(res_sel_o), .res_adr_o(res_adr_o),
    .res_dat_o(res_dat_o), .res_ack_i(res_ack), .res_dat_i(res_rdat), .err_o(err_o)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [31:0] rd;
  } res_t;
  typedef struct packed {
    logic        la;
    logic [31:0] dat;
  } rsp_t;

  res_t        res_q[$];
  rsp_t        rsp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          t0;
  logic [31:0] exp_wb = '0;
  logic [31:0] exp_la = '0;
  res_t        r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_go(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] rd);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_sel = sel; wbs_dat = dat;
    res_q.push_back({we, sel, adr[9:2], dat, rd});
    if (!we) exp_wb = rd;
    rsp_q.push_back({1'b0, exp_wb});
  endtask

  task automatic la_go(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [31:0] rd);
    la_req = 1'b1; la_we = we; la_adr = adr; la_dat = dat;
    res_q.push_back({we, 4'hF, adr, dat, rd});
    if (!we) exp_la = rd;
    rsp_q.push_back({1'b1, exp_la});
  endtask

  task automatic wait_grant(input string tag, output res_t rx);
    int n = 0;
    while (res_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 64'(res_req_o), 64'd1);
    chk({tag, "_qres"}, 64'(res_q.size() > 0), 64'd1);
    rx = '0;
    if (res_q.size() > 0) rx = res_q.pop_front();
    chk({tag, "_res"}, {res_we_o, res_sel_o, res_adr_o, res_dat_o},
        {rx.we, rx.sel, rx.adr, rx.dat});
  endtask

  task automatic finish_ack(input string tag);
    int   n = 0;
    rsp_t p;
    while (!(wbs_ack_o | la_ack_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, 64'(wbs_ack_o | la_ack_o), 64'd1);
    ack_cyc = cyc;
    chk({tag, "_qrsp"}, 64'(rsp_q.size() > 0), 64'd1);
    p = '0;
    if (rsp_q.size() > 0) p = rsp_q.pop_front();
    chk({tag, "_who"}, {wbs_ack_o, la_ack_o}, {!p.la, p.la});
    chk({tag, "_dat"}, 64'(p.la ? la_dat_o : wbs_dat_o), 64'(p.dat));
    if (wbs_ack_o) begin wbs_cyc = 1'b0; wbs_stb = 1'b0; end
    if (la_ack_o) la_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {wbs_ack_o, la_ack_o}, 2'b00);
  endtask

  task automatic serve(input string tag, input int delay);
    res_t rx;
    wait_grant(tag, rx);
    repeat (delay) @(negedge clk);
    chk({tag, "_hold"}, {res_req_o, res_adr_o}, {1'b1, rx.adr});
    res_ack = 1'b1; res_rdat = rx.rd;
    @(negedge clk);
    res_ack = 1'b0; res_rdat = 32'h0BAD_F00D;
    chk({tag, "_drop"}, 64'(res_req_o), 64'd0);
    finish_ack(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_wb = '0; exp_la = '0;
    res_q.delete(); rsp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
    la_req = 0; la_we = 0; la_adr = 0; la_dat = 0;
    res_ack = 0; res_rdat = 32'h0BAD_F00D;
    #1;
    chk("reset_async", {res_req_o, wbs_ack_o, la_ack_o, err_o, wbs_dat_o, la_dat_o}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WB write, resource answers one cycle after seeing the request
    t0 = cyc;
    wb_go(1'b1, 32'h3000_0010, 4'hF, 32'hA5A5_5A5A, 32'h0);
    serve("wb_wr", 1);
    chk("wb_wr_lat", 64'(ack_cyc - t0), 64'd3);

    // LA read
    la_go(1'b0, 8'h07, 32'h0, 32'h1234_5678);
    serve("la_rd", 0);
    chk("la_rd_held", 64'(la_dat_o), 64'h1234_5678);

    // WB read with partial select
    wb_go(1'b0, 32'h3000_03FC, 4'h3, 32'h0, 32'hCAFE_0001);
    serve("wb_rd", 2);

    // Simultaneous from reset: WB wins, then LA
    do_reset();
    wb_go(1'b1, 32'h3000_0040, 4'hC, 32'h1111_2222, 32'h0);
    la_go(1'b0, 8'h22, 32'h0, 32'h3333_4444);
    serve("both1_wb", 0);
    serve("both1_la", 0);
    // WB alone, then both: LA must win now
    wb_go(1'b0, 32'h3000_0008, 4'hF, 32'h0, 32'h5555_6666);
    serve("wb_solo", 0);
    la_go(1'b1, 8'hF0, 32'h7777_8888, 32'h0);
    wb_go(1'b0, 32'h3000_000C, 4'hF, 32'h0, 32'h9999_AAAA);
    serve("both2_la", 0);
    serve("both2_wb", 0);

    // Out-of-window WB access is ignored
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h2000_0000; wbs_sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen = seen | res_req_o | wbs_ack_o;
    end
    chk("no_window", 64'(seen), 64'd0);
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    @(negedge clk);

    // Reset while the LA access is outstanding
    la_go(1'b0, 8'h33, 32'h0, 32'hDDDD_EEEE);
    void'(rsp_q.pop_back());
    wait_grant("rst_mid", r);
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", 64'(res_req_o), 64'd0);
    la_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_la = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | la_ack_o | res_req_o;
    end
    chk("rst_mid_noack", 64'(seen), 64'd0);
    chk("rst_mid_dat", 64'(la_dat_o), 64'd0);

    // Arbiter still serves normally after the abort
    la_go(1'b0, 8'h01, 32'h0, 32'h0102_0304);
    serve("post_rst", 0);

`ifdef ARB_TIMEOUT_EN
    wb_go(1'b0, 32'h3000_0020, 4'hF, 32'h0, 32'h0);
    void'(rsp_q.pop_back());
    rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
    wait_grant("tmo", r);
    t0 = cyc;
    finish_ack("tmo");
    chk("tmo_cycles", 64'(ack_cyc - t0), 64'd16);
    chk("tmo_err", 64'(err_o), 64'd1);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 64'(err_o), 64'd1);
`else
    chk("err_tied", 64'(err_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
